// File: rtl/minmax_window_tracker_if.sv
// Stream bundle for the min/max window tracker: sample input handshake,
// window-result output handshake and the running status flags.
//
// Handshake rules (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high; ready never depends on valid, and a
// producer holding valid keeps its data stable until the transfer.
interface minmax_window_tracker_if #(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 4
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic             max_eq_min;
  logic             new_max;
  logic             new_min;
  logic [CNT_W-1:0] sample_cnt;

  // Producer of samples / consumer of window results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_min, max_eq_min,
           new_max, new_min, sample_cnt
  );

  // The tracker itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_min, max_eq_min,
           new_max, new_min, sample_cnt
  );
endinterface

// File: rtl/minmax_window_tracker.sv
// Running max/min tracker over windows of WINDOW unsigned samples.
// IDLE waits for the first sample of a window, TRACK folds further samples
// into the running max/min, HOLD presents the window result until taken.
module minmax_window_tracker #(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  minmax_window_tracker_if.slave   bus,
  output logic [1:0]               state_dbg
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_max_q, new_max_d;
  logic             new_min_q, new_min_d;
  logic             accept;

  // Sample acceptance; ready is a pure function of state
  assign accept = bus.in_valid && (state_q != HOLD);

  // Next-state and next-datapath; both comparisons use pre-update max/min
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    cnt_d     = cnt_q;
    new_max_d = 1'b0;
    new_min_d = 1'b0;

    if (clear) begin
      // Window abort wins over everything; an offered sample is dropped
      state_d = IDLE;
      max_d   = '0;
      min_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            max_d     = bus.in_data;
            min_d     = bus.in_data;
            new_max_d = 1'b1;
            new_min_d = 1'b1;
            cnt_d     = CNT_W'(1);
            state_d   = (WINDOW == 1) ? HOLD : TRACK;
          end
        end
        TRACK: begin
          if (accept) begin
            if (bus.in_data > max_q) begin
              max_d     = bus.in_data;
              new_max_d = 1'b1;
            end
            if (bus.in_data < min_q) begin
              min_d     = bus.in_data;
              new_min_d = 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WINDOW - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // max/min are kept visible after hand-off until the next sample
          if (bus.out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          max_d   = '0;
          min_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      new_max_q <= 1'b0;
      new_min_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      new_max_q <= new_max_d;
      new_min_q <= new_min_d;
    end
  end

  assign bus.in_ready   = (state_q != HOLD);
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_max    = max_q;
  assign bus.out_min    = min_q;
  assign bus.max_eq_min = (cnt_q != '0) && (max_q == min_q);
  assign bus.new_max    = new_max_q;
  assign bus.new_min    = new_min_q;
  assign bus.sample_cnt = cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_minmax_window_tracker.sv
// Directed bench for minmax_window_tracker (WIDTH=3, WINDOW=4).
// A small reference model predicts per-sample pulses and running values;
// window results are queued when the last sample is driven and popped when
// the tracker presents out_valid.
module tb_minmax_window_tracker;
  localparam int WIDTH  = 3;
  localparam int WINDOW = 4;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [1:0] state_dbg;

  minmax_window_tracker_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

  minmax_window_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [2*WIDTH-1:0] exp_q[$];

  // Reference model state
  int m_max = 0;
  int m_min = 0;
  int m_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set, wait the edge, settle 1 time unit
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_max = 0;
    m_min = 0;
    m_cnt = 0;
  endtask

  // Drive one sample, check pulses/running values, then idle 'gap' cycles
  task automatic send(input int d, input int gap);
    int exp_nmax;
    int exp_nmin;
    check("in_ready_before", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(d);
    step();
    bus.in_valid = 1'b0;
    if (m_cnt == 0) begin
      exp_nmax = 1;
      exp_nmin = 1;
      m_max    = d;
      m_min    = d;
    end else begin
      exp_nmax = (d > m_max) ? 1 : 0;
      exp_nmin = (d < m_min) ? 1 : 0;
      if (d > m_max) m_max = d;
      if (d < m_min) m_min = d;
    end
    m_cnt++;
    check("new_max", int'(bus.new_max), exp_nmax);
    check("new_min", int'(bus.new_min), exp_nmin);
    check("run_max", int'(bus.out_max), m_max);
    check("run_min", int'(bus.out_min), m_min);
    check("run_cnt", int'(bus.sample_cnt), m_cnt);
    if (m_cnt == WINDOW) begin
      exp_q.push_back({WIDTH'(m_max), WIDTH'(m_min)});
      check("out_valid_rise", int'(bus.out_valid), 1);
      check("in_ready_hold", int'(bus.in_ready), 0);
    end
    for (int i = 0; i < gap; i++) begin
      step();
      check("gap_new_max", int'(bus.new_max), 0);
      check("gap_new_min", int'(bus.new_min), 0);
    end
  endtask

  // Wait (bounded) for a window result, compare against the queue, take it
  task automatic drain();
    logic [2*WIDTH-1:0] e;
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      step();
      waited++;
    end
    check("out_valid_timeout", int'(bus.out_valid), 1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("win_max", int'(bus.out_max), int'(e[2*WIDTH-1:WIDTH]));
      check("win_min", int'(bus.out_min), int'(e[WIDTH-1:0]));
      check("win_cnt", int'(bus.sample_cnt), WINDOW);
      check("win_eq", int'(bus.max_eq_min), (e[2*WIDTH-1:WIDTH] == e[WIDTH-1:0]) ? 1 : 0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("taken_out_valid", int'(bus.out_valid), 0);
    check("taken_in_ready", int'(bus.in_ready), 1);
    check("taken_cnt", int'(bus.sample_cnt), 0);
    check("taken_eq", int'(bus.max_eq_min), 0);
    check("taken_max_kept", int'(bus.out_max), m_max);
    model_reset();
  endtask

  // Directed sequence
  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_max", int'(bus.out_max), 0);
    check("rst_min", int'(bus.out_min), 0);
    check("rst_cnt", int'(bus.sample_cnt), 0);
    check("rst_pulses", int'({bus.new_max, bus.new_min}), 0);
    check("rst_eq", int'(bus.max_eq_min), 0);
    rst_n = 1'b1;
    step();

    // Back-to-back 5,7,5,2 -> window (7,2); pulse pattern fixed independently
    send(5, 0);
    send(7, 0);
    check("b2b_pulse2", int'({bus.new_max, bus.new_min}), 2'b10);
    send(5, 0);
    check("b2b_pulse3", int'({bus.new_max, bus.new_min}), 2'b00);
    send(2, 0);
    check("b2b_pulse4", int'({bus.new_max, bus.new_min}), 2'b01);
    check("b2b_max", int'(bus.out_max), 7);
    check("b2b_min", int'(bus.out_min), 2);
    drain();

    // All-equal window: only the first sample pulses
    send(5, 0);
    send(5, 0);
    send(5, 0);
    send(5, 0);
    check("eq_flag", int'(bus.max_eq_min), 1);
    drain();

    // HOLD stall: offered samples ignored while result not taken
    send(1, 0);
    send(6, 0);
    send(3, 0);
    send(3, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 3'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", int'(bus.out_valid), 1);
      check("stall_ready", int'(bus.in_ready), 0);
      check("stall_cnt", int'(bus.sample_cnt), 4);
      check("stall_max", int'(bus.out_max), 6);
      check("stall_min", int'(bus.out_min), 1);
      check("stall_pulses", int'({bus.new_max, bus.new_min}), 0);
    end
    bus.in_valid = 1'b0;
    drain();

    // Full-range values then clear with a sample offered
    send(0, 0);
    send(7, 0);
    check("range_max", int'(bus.out_max), 7);
    check("range_min", int'(bus.out_min), 0);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 3'd4;
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    check("clr_cnt", int'(bus.sample_cnt), 0);
    check("clr_max", int'(bus.out_max), 0);
    check("clr_min", int'(bus.out_min), 0);
    check("clr_pulses", int'({bus.new_max, bus.new_min}), 0);
    check("clr_valid", int'(bus.out_valid), 0);
    step();
    check("clr_discard", int'(bus.sample_cnt), 0);

    // Asynchronous reset mid-window, away from the clock edge
    send(2, 0);
    send(6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_max", int'(bus.out_max), 0);
    check("arst_cnt", int'(bus.sample_cnt), 0);
    check("arst_pulses", int'({bus.new_max, bus.new_min}), 0);
    check("arst_ready", int'(bus.in_ready), 1);
    #2;
    rst_n = 1'b1;
    model_reset();
    step();
    send(3, 0);
    send(0, 0);
    send(7, 0);
    send(4, 0);
    drain();

    // Gapped stream: same window result as back-to-back
    send(5, 2);
    send(7, 2);
    send(5, 2);
    send(2, 0);
    check("gap_max", int'(bus.out_max), 7);
    check("gap_min", int'(bus.out_min), 2);
    drain();

    // A few random windows with random gaps
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < WINDOW; s++) begin
        send(int'($urandom_range(0, 7)), (s == WINDOW - 1) ? 0 : int'($urandom_range(0, 2)));
      end
      drain();
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
